vend_dispense_responder: RTL and testbench

//  Mechanism-side responder for the vending controller's serve/change/done handshake.
//  - Accepts single-cycle serve and change strobes.
//  - Drives the vend motor or the nickel-eject solenoid for a fixed time.
//  - Returns a multi-cycle done pulse.
//  - Tracks product stock and flags overrun and sold-out. Sits between the controller and the actuators.

---
 rtl/vend_dispense_if.sv | 10 +
 rtl/vend_dispense_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_vend_dispense_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_if.sv
// Serve/change/done handshake between the vending controller (master)
// and the dispense mechanism responder (slave).
interface vend_dispense_if;
    logic serve;   // 1-cycle strobe: dispense one item
    logic change;  // 1-cycle strobe: eject one nickel
    logic done;    // action-complete pulse

    modport master (output serve, output change, input done);
    modport slave  (input serve, input change, output done);
endinterface

// File: rtl/vend_dispense_responder.sv
// Mechanism-side responder: runs the vend motor or nickel solenoid for a
// fixed time per strobe, returns a multi-cycle done pulse, keeps stock and
// flags overrun / sold-out. One pending slot per strobe type.
// Optional macro JAM_DETECT_EN adds a VWAIT state that waits for the drop
// sensor after the motor run and flags a sticky jam on timeout.
module vend_dispense_responder #(
    parameter int VEND_CYCLES = 8,
    parameter int COIN_CYCLES = 4,
    parameter int ACK_CYCLES  = 2,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 15,
    parameter int JAM_TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    vend_dispense_if.slave     bus,
    input  logic               restock,
    input  logic               item_sensed,
    output logic               vend_motor,
    output logic               coin_eject,
    output logic [STOCK_W-1:0] stock,
    output logic               sold_out,
    output logic               overrun,
    output logic               jam
);

    localparam int MAX_A = (VEND_CYCLES > COIN_CYCLES) ? VEND_CYCLES : COIN_CYCLES;
    localparam int MAX_B = (MAX_A > ACK_CYCLES) ? MAX_A : ACK_CYCLES;
    localparam int MAX_C = (MAX_B > JAM_TIMEOUT) ? MAX_B : JAM_TIMEOUT;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0]   VEND_LAST = CNT_W'(VEND_CYCLES - 1);
    localparam logic [CNT_W-1:0]   COIN_LAST = CNT_W'(COIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   ACK_LAST  = CNT_W'(ACK_CYCLES - 1);
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        COIN,
`ifdef JAM_DETECT_EN
        VWAIT,
`endif
        ACK
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               vend_q, coin_q, done_q;
    logic               pend_serve_q, pend_serve_d;
    logic               pend_change_q, pend_change_d;
    logic               overrun_q, overrun_d;
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic               sold_out_q;
    logic               take_serve, take_change;

`ifdef JAM_DETECT_EN
    localparam logic [CNT_W-1:0] JAM_LAST = CNT_W'(JAM_TIMEOUT - 1);
    logic jam_q, seen_q;
`else
    // Drop sensor has no role without jam detection.
    logic unused_item_sensed;
    assign unused_item_sensed = item_sensed;
`endif

    // Arbitration in IDLE (serve wins) and the one-deep pending slots / overrun.
    always_comb begin
        take_serve    = (state_q == IDLE) && (bus.serve | pend_serve_q);
        take_change   = (state_q == IDLE) && !take_serve && (bus.change | pend_change_q);
        pend_serve_d  = pend_serve_q;
        pend_change_d = pend_change_q;
        overrun_d     = overrun_q;
        // A consumed slot stays full only if a fresh strobe arrives at the same edge.
        if (take_serve)
            pend_serve_d = pend_serve_q & bus.serve;
        else if (bus.serve) begin
            if (pend_serve_q) overrun_d = 1'b1;
            else              pend_serve_d = 1'b1;
        end
        if (take_change)
            pend_change_d = pend_change_q & bus.change;
        else if (bus.change) begin
            if (pend_change_q) overrun_d = 1'b1;
            else               pend_change_d = 1'b1;
        end
    end

    // Stock next value: decrement on vend entry, jam refund, restock overrides both.
    always_comb begin
        stock_d = stock_q;
        if (take_serve && stock_q != '0)
            stock_d = stock_q - 1'b1;
`ifdef JAM_DETECT_EN
        if (state_q == VWAIT && !item_sensed && cnt_q == JAM_LAST && stock_q != '1)
            stock_d = stock_q + 1'b1;
`endif
        if (restock)
            stock_d = STOCK_RST;
    end

    // Bookkeeping registers: pending slots, overrun, stock and sold-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_serve_q  <= 1'b0;
            pend_change_q <= 1'b0;
            overrun_q     <= 1'b0;
            stock_q       <= STOCK_RST;
            sold_out_q    <= (STOCK_INIT == 0);
        end else begin
            pend_serve_q  <= pend_serve_d;
            pend_change_q <= pend_change_d;
            overrun_q     <= overrun_d;
            stock_q       <= stock_d;
            sold_out_q    <= (stock_d == '0);
        end
    end

    // Main FSM with registered drives; at most one drive is set per state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vend_q  <= 1'b0;
            coin_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef JAM_DETECT_EN
            jam_q   <= 1'b0;
            seen_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (take_serve) begin
`ifdef JAM_DETECT_EN
                        seen_q <= 1'b0;
`endif
                        if (stock_q == '0) begin
                            // Sold out: skip the motor but still acknowledge.
                            state_q <= ACK;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= VEND;
                            vend_q  <= 1'b1;
                        end
                    end else if (take_change) begin
                        state_q <= COIN;
                        coin_q  <= 1'b1;
                    end
                end
                VEND: begin
`ifdef JAM_DETECT_EN
                    seen_q <= seen_q | item_sensed;
`endif
                    if (cnt_q == VEND_LAST) begin
                        vend_q <= 1'b0;
                        cnt_q  <= '0;
`ifdef JAM_DETECT_EN
                        if (seen_q | item_sensed) begin
                            state_q <= ACK;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= VWAIT;
                        end
`else
                        state_q <= ACK;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef JAM_DETECT_EN
                VWAIT: begin
                    if (item_sensed || cnt_q == JAM_LAST) begin
                        if (!item_sensed) jam_q <= 1'b1;
                        state_q <= ACK;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                COIN: begin
                    if (cnt_q == COIN_LAST) begin
                        coin_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ACK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    if (cnt_q == ACK_LAST) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    vend_q  <= 1'b0;
                    coin_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done   = done_q;
    assign vend_motor = vend_q;
    assign coin_eject = coin_q;
    assign stock      = stock_q;
    assign sold_out   = sold_out_q;
    assign overrun    = overrun_q;
`ifdef JAM_DETECT_EN
    assign jam        = jam_q;
`else
    assign jam        = 1'b0;
`endif

endmodule

// File: tb/tb_vend_dispense_responder.sv
// Directed bench for vend_dispense_responder (default parameters).
module tb_vend_dispense_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restock = 1'b0;
    logic       item_sensed = 1'b0;
    logic       vend_motor, coin_eject, sold_out, overrun, jam;
    logic [3:0] stock;

    vend_dispense_if u_if();

    vend_dispense_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if.slave),
        .restock     (restock),
        .item_sensed (item_sensed),
        .vend_motor  (vend_motor),
        .coin_eject  (coin_eject),
        .stock       (stock),
        .sold_out    (sold_out),
        .overrun     (overrun),
        .jam         (jam)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Capture statistics over a window of cycles.
    int vcnt, ccnt, dcnt, dpulses, vfirst, cfirst, dfirst, overlap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Assert strobes for one cycle; returns at the negedge just after the sampling edge.
    task automatic strobe(input logic s, input logic c);
        @(negedge clk);
        u_if.serve  = s;
        u_if.change = c;
        @(negedge clk);
    endtask

    // Sample drives on n consecutive negedges; masks give extra strobes per cycle.
    task automatic capture(input int n, input logic [63:0] smask, input logic [63:0] cmask);
        logic dprev;
        vcnt = 0; ccnt = 0; dcnt = 0; dpulses = 0; overlap = 0;
        vfirst = -1; cfirst = -1; dfirst = -1;
        dprev = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (vend_motor) begin vcnt++; if (vfirst < 0) vfirst = i; end
            if (coin_eject) begin ccnt++; if (cfirst < 0) cfirst = i; end
            if (u_if.done)  begin dcnt++; if (dfirst < 0) dfirst = i; end
            if (u_if.done && !dprev) dpulses++;
            dprev = u_if.done;
            if (int'(vend_motor) + int'(coin_eject) + int'(u_if.done) > 1) overlap++;
            u_if.serve  = smask[i];
            u_if.change = cmask[i];
            @(negedge clk);
        end
        u_if.serve  = 1'b0;
        u_if.change = 1'b0;
    endtask

    initial begin
        u_if.serve  = 1'b0;
        u_if.change = 1'b0;
        do_reset();

        // Reset state
        chk("rst_done", u_if.done, 0);
        chk("rst_vend", vend_motor, 0);
        chk("rst_coin", coin_eject, 0);
        chk("rst_stock", stock, 15);
        chk("rst_sold", sold_out, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_jam", jam, 0);

        // 1: single serve
        strobe(1'b1, 1'b0);
        capture(14, '0, '0);
        chk("t1_vcnt", vcnt, 8);
        chk("t1_vfirst", vfirst, 0);
        chk("t1_dcnt", dcnt, 2);
        chk("t1_dfirst", dfirst, 8);
        chk("t1_stock", stock, 14);
        chk("t1_idle", {vend_motor, coin_eject, u_if.done}, 0);

        // 2: serve and change together, serve wins, change pended
        strobe(1'b1, 1'b1);
        capture(24, '0, '0);
        chk("t2_vcnt", vcnt, 8);
        chk("t2_ccnt", ccnt, 4);
        chk("t2_cfirst", cfirst, 11);
        chk("t2_dpulses", dpulses, 2);
        chk("t2_overlap", overlap, 0);
        chk("t2_ovr", overrun, 0);
        chk("t2_stock", stock, 13);

        // 3: serves during VEND: one pended, next overruns
        strobe(1'b1, 1'b0);
        capture(26, 64'h14, '0);
        chk("t3_vcnt", vcnt, 16);
        chk("t3_dpulses", dpulses, 2);
        chk("t3_v2first_gap", dcnt, 4);
        chk("t3_ovr", overrun, 1);
        chk("t3_stock", stock, 11);
        repeat (3) @(negedge clk);
        chk("t3_ovr_sticky", overrun, 1);

        // 4: drain stock to zero
        do_reset();
        chk("t4_ovr_clr", overrun, 0);
        for (int k = 0; k < 15; k++) begin
            strobe(1'b1, 1'b0);
            capture(12, '0, '0);
            if (k == 13) begin
                chk("t4_stock1", stock, 1);
                chk("t4_sold1", sold_out, 0);
            end
        end
        chk("t4_stock0", stock, 0);
        chk("t4_sold0", sold_out, 1);
        strobe(1'b1, 1'b0);
        capture(6, '0, '0);
        chk("t4_empty_vcnt", vcnt, 0);
        chk("t4_empty_dfirst", dfirst, 0);
        chk("t4_empty_dcnt", dcnt, 2);
        chk("t4_empty_stock", stock, 0);
        @(negedge clk);
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        chk("t4_restock", stock, 15);
        chk("t4_restock_sold", sold_out, 0);

        // restock coincident with a vend-entry decrement: restock wins
        @(negedge clk);
        u_if.serve = 1'b1;
        restock    = 1'b1;
        @(negedge clk);
        u_if.serve = 1'b0;
        restock    = 1'b0;
        chk("t4_rs_vend", vend_motor, 1);
        chk("t4_rs_stock", stock, 15);
        capture(12, '0, '0);
        chk("t4_rs_dpulses", dpulses, 1);

`ifdef JAM_DETECT_EN
        // 5: no sensor -> VWAIT timeout, jam, stock refunded
        strobe(1'b1, 1'b0);
        capture(45, '0, '0);
        chk("t5_vcnt", vcnt, 8);
        chk("t5_dfirst", dfirst, 40);
        chk("t5_dcnt", dcnt, 2);
        chk("t5_jam", jam, 1);
        chk("t5_stock", stock, 15);
        item_sensed = 1'b1;
        strobe(1'b1, 1'b0);
        capture(14, '0, '0);
        item_sensed = 1'b0;
        chk("t5_seen_dfirst", dfirst, 8);
        chk("t5_seen_stock", stock, 14);
`else
        // sensor ignored without jam detection
        strobe(1'b1, 1'b0);
        capture(14, '0, '0);
        chk("t5_nojam_dfirst", dfirst, 8);
        chk("t5_nojam_jam", jam, 0);
        chk("t5_nojam_stock", stock, 14);
`endif

        // 6: async reset mid-VEND
        strobe(1'b1, 1'b0);
        capture(4, '0, '0);
        chk("t6_vend_pre", vend_motor, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_vend_async", vend_motor, 0);
        chk("t6_done_async", u_if.done, 0);
        chk("t6_stock_async", stock, 15);
        @(negedge clk);
        rst_n = 1'b1;
        capture(15, '0, '0);
        chk("t6_post_vcnt", vcnt, 0);
        chk("t6_post_dpulses", dpulses, 0);
        chk("t6_post_stock", stock, 15);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
